// File: rtl/rs_issue_select.sv
// rtl/rs_issue_select.sv - round-robin issue select from the RS into two FU issue latches (port 1 enabled by RS_ISSUE_DUAL_EN)
module rs_issue_select #(
  parameter int RS_SIZE = 8,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 5,
  parameter int ROB_W   = 5,
  parameter int OP_W    = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [RS_SIZE-1:0]        rs_ready_in,
  input  logic [RS_SIZE*DATA_W-1:0] rs_opa_in,
  input  logic [RS_SIZE*DATA_W-1:0] rs_opb_in,
  input  logic [RS_SIZE*TAG_W-1:0]  rs_dest_in,
  input  logic [RS_SIZE*ROB_W-1:0]  rs_rob_in,
  input  logic [RS_SIZE*OP_W-1:0]   rs_op_in,
  output logic [RS_SIZE-1:0]        rs_free_out,
  input  logic [1:0]                fu_ready_in,
  output logic [1:0]                fu_valid_out,
  output logic [2*DATA_W-1:0]       fu_opa_out,
  output logic [2*DATA_W-1:0]       fu_opb_out,
  output logic [2*TAG_W-1:0]        fu_dest_out,
  output logic [2*ROB_W-1:0]        fu_rob_out,
  output logic [2*OP_W-1:0]         fu_op_out
);

  localparam int PTR_W = $clog2(RS_SIZE);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_nxt;
  logic [1:0]        port_free;
  logic [1:0]        cand_vld;
  logic [PTR_W-1:0]  cand_idx [2];
  logic [PTR_W-1:0]  scan_idx;
  logic [1:0]        grant;
  logic [PTR_W-1:0]  grant_idx [2];

  logic [1:0]        vld_q;
  logic [DATA_W-1:0] opa_q  [2];
  logic [DATA_W-1:0] opb_q  [2];
  logic [TAG_W-1:0]  dest_q [2];
  logic [ROB_W-1:0]  rob_q  [2];
  logic [OP_W-1:0]   op_q   [2];

  // A port can take a new instruction if it is empty or its FU consumes it this cycle.
`ifdef RS_ISSUE_DUAL_EN
  assign port_free = ~vld_q | fu_ready_in;
`else
  // Port 1 never becomes free, so it is never granted and its latch stays at reset value.
  logic unused_fu_ready_1;
  assign unused_fu_ready_1 = fu_ready_in[1];
  assign port_free = {1'b0, ~vld_q[0] | fu_ready_in[0]};
`endif

  // Scan entries from ptr upward (wrapping) and pick the first two ready ones.
  always_comb begin
    cand_vld    = 2'b00;
    cand_idx[0] = '0;
    cand_idx[1] = '0;
    scan_idx    = '0;
    for (int k = 0; k < RS_SIZE; k++) begin
      scan_idx = ptr + PTR_W'(k);
      if (rs_ready_in[scan_idx]) begin
        if (!cand_vld[0]) begin
          cand_vld[0] = 1'b1;
          cand_idx[0] = scan_idx;
        end else if (!cand_vld[1]) begin
          cand_vld[1] = 1'b1;
          cand_idx[1] = scan_idx;
        end
      end
    end
  end

  // Map candidates onto free ports (first candidate to lowest free port), build free pulses and next ptr.
  always_comb begin
    grant        = 2'b00;
    grant_idx[0] = cand_idx[0];
    grant_idx[1] = cand_idx[1];
    rs_free_out  = '0;
    ptr_nxt      = ptr;
    if (reset && !flush) begin
      if (port_free[0]) begin
        grant[0] = cand_vld[0];
        grant[1] = port_free[1] & cand_vld[1];
      end else if (port_free[1]) begin
        grant[1]     = cand_vld[0];
        grant_idx[1] = cand_idx[0];
      end
      if (grant[0]) rs_free_out[grant_idx[0]] = 1'b1;
      if (grant[1]) rs_free_out[grant_idx[1]] = 1'b1;
      // Port 1's entry is always the later one in scan order when both ports grant.
      if (grant[1]) begin
        ptr_nxt = grant_idx[1] + PTR_W'(1);
      end else if (grant[0]) begin
        ptr_nxt = grant_idx[0] + PTR_W'(1);
      end
    end
  end

  // Round-robin pointer; flush leaves it alone because no grants happen that cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  // Issue latches: load on grant, drain when consumed without refill, hold while stalled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        opa_q[p]  <= '0;
        opb_q[p]  <= '0;
        dest_q[p] <= '0;
        rob_q[p]  <= '0;
        op_q[p]   <= '0;
      end
    end else if (flush) begin
      vld_q <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (grant[p]) begin
          vld_q[p]  <= 1'b1;
          opa_q[p]  <= rs_opa_in[int'(grant_idx[p])*DATA_W +: DATA_W];
          opb_q[p]  <= rs_opb_in[int'(grant_idx[p])*DATA_W +: DATA_W];
          dest_q[p] <= rs_dest_in[int'(grant_idx[p])*TAG_W +: TAG_W];
          rob_q[p]  <= rs_rob_in[int'(grant_idx[p])*ROB_W +: ROB_W];
          op_q[p]   <= rs_op_in[int'(grant_idx[p])*OP_W +: OP_W];
        end else if (port_free[p]) begin
          vld_q[p] <= 1'b0;
        end
      end
    end
  end

  assign fu_valid_out = vld_q;
  assign fu_opa_out   = {opa_q[1], opa_q[0]};
  assign fu_opb_out   = {opb_q[1], opb_q[0]};
  assign fu_dest_out  = {dest_q[1], dest_q[0]};
  assign fu_rob_out   = {rob_q[1], rob_q[0]};
  assign fu_op_out    = {op_q[1], op_q[0]};

endmodule

// File: tb/tb_rs_issue_select.sv
// tb/tb_rs_issue_select.sv - scoreboard bench for rs_issue_select (single- or dual-port via RS_ISSUE_DUAL_EN)
module tb_rs_issue_select;

  localparam int RS = 8;
  localparam int DW = 64;
  localparam int TW = 5;
  localparam int RW = 5;
  localparam int OW = 5;
`ifdef RS_ISSUE_DUAL_EN
  localparam int NPORT = 2;
`else
  localparam int NPORT = 1;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic [RS-1:0]     rs_ready_in = '0;
  logic [RS*DW-1:0]  rs_opa_in = '0;
  logic [RS*DW-1:0]  rs_opb_in = '0;
  logic [RS*TW-1:0]  rs_dest_in = '0;
  logic [RS*RW-1:0]  rs_rob_in = '0;
  logic [RS*OW-1:0]  rs_op_in = '0;
  logic [RS-1:0]     rs_free_out;
  logic [1:0]        fu_ready_in = 2'b00;
  logic [1:0]        fu_valid_out;
  logic [2*DW-1:0]   fu_opa_out;
  logic [2*DW-1:0]   fu_opb_out;
  logic [2*TW-1:0]   fu_dest_out;
  logic [2*RW-1:0]   fu_rob_out;
  logic [2*OW-1:0]   fu_op_out;

  rs_issue_select #(.RS_SIZE(RS), .DATA_W(DW), .TAG_W(TW), .ROB_W(RW), .OP_W(OW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .rs_ready_in(rs_ready_in), .rs_opa_in(rs_opa_in), .rs_opb_in(rs_opb_in),
    .rs_dest_in(rs_dest_in), .rs_rob_in(rs_rob_in), .rs_op_in(rs_op_in),
    .rs_free_out(rs_free_out), .fu_ready_in(fu_ready_in), .fu_valid_out(fu_valid_out),
    .fu_opa_out(fu_opa_out), .fu_opb_out(fu_opb_out), .fu_dest_out(fu_dest_out),
    .fu_rob_out(fu_rob_out), .fu_op_out(fu_op_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]      vld;
    logic [2*DW-1:0] opa;
    logic [2*DW-1:0] opb;
    logic [2*TW-1:0] dest;
    logic [2*RW-1:0] rob;
    logic [2*OW-1:0] op;
    int              ptr;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          m;
  logic [RS-1:0] m_last_free = '0;
  logic [RS-1:0] last_free;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_fields(input bit ident);
    for (int i = 0; i < RS; i++) begin
      rs_opa_in[i*DW +: DW] = {$urandom, $urandom};
      rs_opb_in[i*DW +: DW] = {$urandom, $urandom};
      rs_dest_in[i*TW +: TW] = ident ? TW'(i) : TW'($urandom);
      rs_rob_in[i*RW +: RW] = RW'($urandom);
      rs_op_in[i*OW +: OW] = OW'($urandom);
    end
  endtask

  // One clock: reference grant model at negedge, scoreboard push, pop/compare after the edge.
  task automatic step();
    logic [RS-1:0] efree;
    int            cand[$];
    int            ports[$];
    int            ng;
    int            e;
    int            p;
    exp_t          n;
    exp_t          got;
    @(negedge clock);
    efree = '0;
    ng = 0;
    n = m;
    if (!reset) begin
      n.vld = 2'b00; n.opa = '0; n.opb = '0; n.dest = '0; n.rob = '0; n.op = '0; n.ptr = 0;
    end else if (flush) begin
      n.vld = 2'b00;
    end else begin
      for (int k = 0; k < RS; k++)
        if (rs_ready_in[(m.ptr + k) % RS]) cand.push_back((m.ptr + k) % RS);
      for (int q = 0; q < NPORT; q++)
        if (!m.vld[q] || fu_ready_in[q]) ports.push_back(q);
      ng = (cand.size() < ports.size()) ? cand.size() : ports.size();
      foreach (ports[q]) n.vld[ports[q]] = 1'b0;
      for (int j = 0; j < ng; j++) begin
        e = cand[j];
        p = ports[j];
        efree[e] = 1'b1;
        n.vld[p] = 1'b1;
        n.opa[p*DW +: DW] = rs_opa_in[e*DW +: DW];
        n.opb[p*DW +: DW] = rs_opb_in[e*DW +: DW];
        n.dest[p*TW +: TW] = rs_dest_in[e*TW +: TW];
        n.rob[p*RW +: RW] = rs_rob_in[e*RW +: RW];
        n.op[p*OW +: OW] = rs_op_in[e*OW +: OW];
        n.ptr = (e + 1) % RS;
      end
    end
    last_free = rs_free_out;
    check_val("rs_free", rs_free_out, efree);
    check_val("free_popcnt", ($countones(rs_free_out) <= NPORT), 1);
    check_val("free_not_ready", rs_free_out & ~rs_ready_in, 0);
    sb_q.push_back(n);
    m = n;
    m_last_free = efree;
    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    check_val("fu_valid", fu_valid_out, got.vld);
    check_val("fu_opa", fu_opa_out, got.opa);
    check_val("fu_opb", fu_opb_out, got.opb);
    check_val("fu_dest", fu_dest_out, got.dest);
    check_val("fu_rob", fu_rob_out, got.rob);
    check_val("fu_op", fu_op_out, got.op);
    check_val("ptr", dut.ptr, got.ptr);
  endtask

  initial begin
    m.vld = 2'b00; m.opa = '0; m.opb = '0; m.dest = '0; m.rob = '0; m.op = '0; m.ptr = 0;
    set_fields(1'b1);
    reset = 1'b0;
    rs_ready_in = 8'hFF;
    step();
    step();
    check_val("tp_reset_free", last_free, 8'h00);
    check_val("tp_reset_valid", fu_valid_out, 2'b00);
    reset = 1'b1;
`ifdef RS_ISSUE_DUAL_EN
    step();
    check_val("tp_first_free", last_free, 8'h03);
    check_val("tp_first_valid", fu_valid_out, 2'b11);
    check_val("tp_first_dest", fu_dest_out, {5'd1, 5'd0});
    check_val("tp_first_ptr", dut.ptr, 2);
    fu_ready_in = 2'b11;
    rs_ready_in = 8'h30;
    step();
    check_val("tp_ptr6", dut.ptr, 6);
    rs_ready_in = 8'h81;
    step();
    check_val("tp_wrap_free", last_free, 8'h81);
    check_val("tp_wrap_dest", fu_dest_out, {5'd0, 5'd7});
    check_val("tp_wrap_ptr", dut.ptr, 1);
    fu_ready_in = 2'b00;
    rs_ready_in = 8'h10;
    step();
    check_val("tp_stall_free", last_free, 8'h00);
    check_val("tp_stall_hold", fu_dest_out, {5'd0, 5'd7});
    fu_ready_in = 2'b10;
    step();
    check_val("tp_p1_free", last_free, 8'h10);
    check_val("tp_p1_dest", fu_dest_out, {5'd4, 5'd7});
    check_val("tp_p1_valid", fu_valid_out, 2'b11);
    flush = 1'b1;
    fu_ready_in = 2'b11;
    rs_ready_in = 8'h0F;
    step();
    check_val("tp_flush_free", last_free, 8'h00);
    check_val("tp_flush_valid", fu_valid_out, 2'b00);
    check_val("tp_flush_ptr", dut.ptr, 5);
    flush = 1'b0;
`else
    rs_ready_in = 8'h06;
    fu_ready_in = 2'b01;
    step();
    check_val("tp_sp_free1", last_free, 8'h02);
    check_val("tp_sp_dest1", fu_dest_out[TW-1:0], 5'd1);
    check_val("tp_sp_valid1", fu_valid_out, 2'b01);
    rs_ready_in = 8'h04;
    step();
    check_val("tp_sp_free2", last_free, 8'h04);
    check_val("tp_sp_dest2", fu_dest_out[TW-1:0], 5'd2);
    check_val("tp_sp_valid2", fu_valid_out, 2'b01);
    check_val("tp_sp_ptr", dut.ptr, 3);
    fu_ready_in = 2'b11;
    rs_ready_in = 8'h00;
    step();
    check_val("tp_sp_drain", fu_valid_out, 2'b00);
`endif
    rs_ready_in = 8'h03;
    fu_ready_in = 2'b00;
    step();
    reset = 1'b0;
    step();
    check_val("tp_midstall_reset", fu_valid_out, 2'b00);
    reset = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      set_fields(1'b0);
      rs_ready_in = RS'($urandom) & ~m_last_free;
      fu_ready_in = 2'($urandom);
      flush = ($urandom_range(31) == 0);
      reset = ($urandom_range(255) != 0);
      step();
    end
    check_val("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
